// File: rtl/dstack_pkg.sv
// Shared types and helpers for the data-stack engine and its entry shifter.
package dstack_pkg;

    typedef enum logic [1:0] {
        MV_HOLD = 2'b00,
        MV_PUSH = 2'b01,
        MV_POP1 = 2'b10,
        MV_POP2 = 2'b11
    } movement_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SPILL = 2'b01,
        ST_FILL  = 2'b10
    } dstack_state_t;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_SPILL_W    = 16;
    localparam int DEFAULT_REFILL     = 4;

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dstack_shifter.sv
// Combinational next-state of the on-chip entry window for one fired op.
// Entry 0 always takes next_top; deeper entries move according to movement/rotate.
module dstack_shifter
    import dstack_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = addr_width(DEFAULT_DEPTH)
) (
    input  logic [DEPTH-1:0][WORD_WIDTH-1:0] old_entries,
    input  movement_t                        movement,
    input  logic                             op_rotate,
    input  logic [ADDR_W-1:0]                op_addr,
    input  logic [WORD_WIDTH-1:0]            next_top,
    output logic [DEPTH-1:0][WORD_WIDTH-1:0] new_entries
);

    // Pops zero-fill the vacated bottom so entries beyond occupancy stay clean.
    always_comb begin
        new_entries = old_entries;
        case (movement)
            MV_PUSH: begin
                for (int i = 1; i < DEPTH; i++) begin
                    new_entries[i] = old_entries[i-1];
                end
            end
            MV_POP1: begin
                for (int i = 1; i < DEPTH-1; i++) begin
                    new_entries[i] = old_entries[i+1];
                end
                new_entries[DEPTH-1] = '0;
            end
            MV_POP2: begin
                for (int i = 1; i < DEPTH-2; i++) begin
                    new_entries[i] = old_entries[i+2];
                end
                new_entries[DEPTH-2] = '0;
                new_entries[DEPTH-1] = '0;
            end
            default: begin
                if (op_rotate) begin
                    for (int i = 1; i < DEPTH; i++) begin
                        if (ADDR_W'(i) <= op_addr) begin
                            new_entries[i] = old_entries[i-1];
                        end
                    end
                end
            end
        endcase
        new_entries[0] = next_top;
    end

endmodule

// File: rtl/dstack_engine.sv
// Data-stack storage engine: on-chip entry window, spill/fill to a LIFO backing
// store, valid/ready op handshake and sticky over/underflow flags.
module dstack_engine
    import dstack_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int SPILL_W    = DEFAULT_SPILL_W,
    parameter int REFILL     = DEFAULT_REFILL,
    localparam int ADDR_W    = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  movement_t             movement,
    input  logic                  op_rotate,
    input  logic [ADDR_W-1:0]     op_addr,
    input  logic [WORD_WIDTH-1:0] next_top,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [ADDR_W:0]       occupancy,
    output logic [SPILL_W-1:0]    spilled,
    output logic                  spill_valid,
    output logic [WORD_WIDTH-1:0] spill_data,
    input  logic                  spill_ready,
    output logic                  fill_req,
    input  logic                  fill_valid,
    input  logic [WORD_WIDTH-1:0] fill_data,
    output logic                  overflow_err,
    output logic                  underflow_err,
    input  logic                  clear_err
);

    localparam logic [SPILL_W-1:0] SPILL_MAX = '1;
    localparam logic [ADDR_W:0]    DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]    REFILL_C  = (ADDR_W+1)'(REFILL);

    logic [DEPTH-1:0][WORD_WIDTH-1:0] entries, entries_next, shifted;
    logic [ADDR_W:0]                  occ_next;
    logic [SPILL_W-1:0]               spilled_next;
    dstack_state_t                    state, state_next;
    logic                             spill_due, fill_due, op_fire;
    logic                             ovf_set, unf_set;

    assign spill_due = (occupancy == DEPTH_C) && (spilled != SPILL_MAX);
    assign fill_due  = (occupancy < REFILL_C) && (spilled != '0);
    assign op_ready  = (state == ST_IDLE) && !spill_due && !fill_due;
    assign op_fire   = op_valid && op_ready;

    assign top          = entries[0];
    assign second       = entries[1];
    assign third        = entries[2];
    assign spill_data   = entries[DEPTH-1];
    assign spill_valid  = (state == ST_SPILL);
    assign fill_req     = (state == ST_FILL);
    assign rotate_value = ({1'b0, op_addr} < occupancy) ? entries[op_addr] : '0;

    dstack_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_shifter (
        .old_entries (entries),
        .movement    (movement),
        .op_rotate   (op_rotate),
        .op_addr     (op_addr),
        .next_top    (next_top),
        .new_entries (shifted)
    );

    // A fired op owns the cycle; spill/fill sequencing only advances on idle cycles.
    always_comb begin
        entries_next = entries;
        occ_next     = occupancy;
        spilled_next = spilled;
        state_next   = state;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        if (op_fire) begin
            entries_next = shifted;
            case (movement)
                MV_PUSH: begin
                    if (occupancy == DEPTH_C) begin
                        ovf_set = 1'b1;
                    end else begin
                        occ_next = occupancy + 1'b1;
                    end
                end
                MV_POP1: begin
                    unf_set  = (occupancy < (ADDR_W+1)'(2));
                    occ_next = (occupancy == '0) ? '0 : occupancy - 1'b1;
                end
                MV_POP2: begin
                    unf_set  = (occupancy < (ADDR_W+1)'(3));
                    occ_next = (occupancy < (ADDR_W+1)'(2)) ? '0 : occupancy - (ADDR_W+1)'(2);
                end
                default: begin
                    unf_set = op_rotate && ({1'b0, op_addr} >= occupancy);
                end
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (spill_due) begin
                        state_next = ST_SPILL;
                    end else if (fill_due) begin
                        state_next = ST_FILL;
                    end
                end
                ST_SPILL: begin
                    if (spill_ready) begin
                        entries_next[DEPTH-1] = '0;
                        occ_next              = occupancy - 1'b1;
                        spilled_next          = spilled + 1'b1;
                        state_next            = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        entries_next[occupancy[ADDR_W-1:0]] = fill_data;
                        occ_next                            = occupancy + 1'b1;
                        spilled_next                        = spilled - 1'b1;
                        if (!(((occupancy + 1'b1) < REFILL_C) && (spilled > SPILL_W'(1)))) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries       <= '0;
            occupancy     <= '0;
            spilled       <= '0;
            state         <= ST_IDLE;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            entries       <= entries_next;
            occupancy     <= occ_next;
            spilled       <= spilled_next;
            state         <= state_next;
            overflow_err  <= ovf_set | (overflow_err & ~clear_err);
            underflow_err <= unf_set | (underflow_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_dstack_engine.sv
// Directed bench for dstack_engine (DEPTH=8, SPILL_W=2 so saturation is reachable).
module tb_dstack_engine;
    import dstack_pkg::*;

    localparam int WW     = 32;
    localparam int DEPTH  = 8;
    localparam int SW     = 2;
    localparam int REFILL = 4;
    localparam int AW     = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            op_valid = 1'b0;
    logic            op_ready;
    movement_t       movement = MV_HOLD;
    logic            op_rotate = 1'b0;
    logic [AW-1:0]   op_addr = '0;
    logic [WW-1:0]   next_top = '0;
    logic [WW-1:0]   top, second, third, rotate_value, spill_data;
    logic [AW:0]     occupancy;
    logic [SW-1:0]   spilled;
    logic            spill_valid, fill_req;
    logic            spill_ready = 1'b0;
    logic            fill_valid = 1'b0;
    logic [WW-1:0]   fill_data = '0;
    logic            overflow_err, underflow_err;
    logic            clear_err = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;

    dstack_engine #(
        .WORD_WIDTH (WW),
        .DEPTH      (DEPTH),
        .SPILL_W    (SW),
        .REFILL     (REFILL)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .movement      (movement),
        .op_rotate     (op_rotate),
        .op_addr       (op_addr),
        .next_top      (next_top),
        .top           (top),
        .second        (second),
        .third         (third),
        .rotate_value  (rotate_value),
        .occupancy     (occupancy),
        .spilled       (spilled),
        .spill_valid   (spill_valid),
        .spill_data    (spill_data),
        .spill_ready   (spill_ready),
        .fill_req      (fill_req),
        .fill_valid    (fill_valid),
        .fill_data     (fill_data),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .clear_err     (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; waits (bounded) for op_ready, fires one op, returns at the next falling edge.
    task automatic apply_stimulus(input movement_t mv, input logic rot, input logic [AW-1:0] addr,
                                  input logic [WW-1:0] nt);
        int waited = 0;
        while (!op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("op_ready_before_op", 32'(op_ready), 1);
        movement  = mv;
        op_rotate = rot;
        op_addr   = addr;
        next_top  = nt;
        op_valid  = 1'b1;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        movement  = MV_HOLD;
        op_rotate = 1'b0;
        @(negedge clk);
    endtask

    task automatic service_spill();
        int waited = 0;
        while (!spill_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("spill_valid_wait", 32'(spill_valid), 1);
        spill_ready = 1'b1;
        @(posedge clk);
        #1;
        spill_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;
        $display("[TB] start");
        repeat (2) @(negedge clk);
        check_output("rst_op_ready", 32'(op_ready), 1);
        check_output("rst_occupancy", 32'(occupancy), 0);
        check_output("rst_top", top, 0);
        check_output("rst_second", second, 0);
        check_output("rst_third", third, 0);
        check_output("rst_spill_valid", 32'(spill_valid), 0);
        check_output("rst_fill_req", 32'(fill_req), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 8; i++) apply_stimulus(MV_PUSH, 1'b0, '0, WW'(i));
        check_output("push8_top", top, 8);
        check_output("push8_second", second, 7);
        check_output("push8_third", third, 6);
        check_output("push8_occupancy", 32'(occupancy), 8);
        check_output("push8_op_ready", 32'(op_ready), 0);
        @(negedge clk);
        check_output("spill_valid", 32'(spill_valid), 1);
        check_output("spill_data", spill_data, 1);
        check_output("spill_op_ready", 32'(op_ready), 0);
        spill_ready = 1'b1;
        @(posedge clk);
        #1;
        spill_ready = 1'b0;
        @(negedge clk);
        check_output("spill_occupancy", 32'(occupancy), 7);
        check_output("spill_spilled", 32'(spilled), 1);
        check_output("spill_done_valid", 32'(spill_valid), 0);

        apply_stimulus(MV_POP2, 1'b0, '0, 32'hAA);
        check_output("pop2a_top", top, 32'hAA);
        check_output("pop2a_second", second, 5);
        check_output("pop2a_occupancy", 32'(occupancy), 5);
        apply_stimulus(MV_POP2, 1'b0, '0, 32'hAA);
        check_output("pop2b_occupancy", 32'(occupancy), 3);
        check_output("pop2b_second", second, 3);
        check_output("pop2b_third", third, 2);
        check_output("pop2b_op_ready", 32'(op_ready), 0);
        @(negedge clk);
        check_output("fill_req", 32'(fill_req), 1);
        check_output("fill_no_spill", 32'(spill_valid), 0);
        fill_valid = 1'b1;
        fill_data  = 32'h1;
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        @(negedge clk);
        op_addr = 3'd3;
        #1;
        check_output("fill_done_req", 32'(fill_req), 0);
        check_output("fill_occupancy", 32'(occupancy), 4);
        check_output("fill_spilled", 32'(spilled), 0);
        check_output("fill_entry3", rotate_value, 1);
        check_output("fill_op_ready", 32'(op_ready), 1);

        apply_stimulus(MV_HOLD, 1'b1, 3'd3, 32'h1);
        check_output("rot_top", top, 1);
        check_output("rot_second", second, 32'hAA);
        check_output("rot_third", third, 3);
        check_output("rot_entry3", rotate_value, 2);
        check_output("rot_occupancy", 32'(occupancy), 4);
        op_addr = 3'd5;
        #1;
        check_output("rot_value_oob", rotate_value, 0);
        check_output("rot_no_underflow", 32'(underflow_err), 0);

        apply_stimulus(MV_HOLD, 1'b0, '0, 32'h55);
        check_output("hold_top", top, 32'h55);
        check_output("hold_second", second, 32'hAA);
        check_output("hold_occupancy", 32'(occupancy), 4);

        apply_stimulus(MV_POP2, 1'b0, '0, 32'h60);
        check_output("pop2c_top", top, 32'h60);
        check_output("pop2c_second", second, 2);
        check_output("pop2c_occupancy", 32'(occupancy), 2);
        apply_stimulus(MV_POP1, 1'b0, '0, 32'h61);
        check_output("pop1a_occupancy", 32'(occupancy), 1);
        check_output("pop1a_second", second, 0);
        check_output("pop1a_underflow", 32'(underflow_err), 0);
        apply_stimulus(MV_POP1, 1'b0, '0, 32'h62);
        check_output("uflow_flag", 32'(underflow_err), 1);
        check_output("uflow_occupancy", 32'(occupancy), 0);
        check_output("uflow_top", top, 32'h62);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        @(negedge clk);
        check_output("clear_err", 32'(underflow_err), 0);
        clear_err = 1'b1;
        apply_stimulus(MV_POP1, 1'b0, '0, 32'h63);
        clear_err = 1'b0;
        check_output("clear_vs_set", 32'(underflow_err), 1);
        check_output("clear_vs_set_occ", 32'(occupancy), 0);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        @(negedge clk);

        for (int i = 1; i <= 8; i++) apply_stimulus(MV_PUSH, 1'b0, '0, 32'h10 + WW'(i));
        service_spill();
        apply_stimulus(MV_PUSH, 1'b0, '0, 32'h19);
        service_spill();
        apply_stimulus(MV_PUSH, 1'b0, '0, 32'h1A);
        service_spill();
        check_output("sat_spilled", 32'(spilled), 3);
        check_output("sat_occupancy7", 32'(occupancy), 7);
        apply_stimulus(MV_PUSH, 1'b0, '0, 32'h1B);
        @(negedge clk);
        check_output("sat_no_spill", 32'(spill_valid), 0);
        check_output("sat_op_ready", 32'(op_ready), 1);
        check_output("sat_bottom", spill_data, 32'h14);
        apply_stimulus(MV_PUSH, 1'b0, '0, 32'hEE);
        check_output("ovf_flag", 32'(overflow_err), 1);
        check_output("ovf_occupancy", 32'(occupancy), 8);
        check_output("ovf_top", top, 32'hEE);
        check_output("ovf_second", second, 32'h1B);
        check_output("ovf_bottom_lost", spill_data, 32'h15);
        check_output("ovf_spilled", 32'(spilled), 3);

        for (int i = 0; i < 3; i++) apply_stimulus(MV_POP2, 1'b0, '0, 32'h70);
        check_output("drain_occupancy", 32'(occupancy), 2);
        waited = 0;
        while (!fill_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("midfill_req", 32'(fill_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("arst_occupancy", 32'(occupancy), 0);
        check_output("arst_spilled", 32'(spilled), 0);
        check_output("arst_top", top, 0);
        check_output("arst_second", second, 0);
        check_output("arst_third", third, 0);
        check_output("arst_fill_req", 32'(fill_req), 0);
        check_output("arst_spill_valid", 32'(spill_valid), 0);
        check_output("arst_overflow", 32'(overflow_err), 0);
        check_output("arst_underflow", 32'(underflow_err), 0);
        check_output("arst_op_ready", 32'(op_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
